// File: rtl/key_round_scheduler.sv
// key_round_scheduler
//   Generates the 16 per-round C/D halves and the 96-bit round subkey for the
//   128-bit expanded DES datapath. Each round rotates both halves by the doubled
//   DES shift amount: left for encrypt order, right for decrypt order. Rounds
//   are handed out one at a time over a valid/ready handshake.
//
// Ports
//   Clk          clock, rising edge
//   Reset        asynchronous active-high reset
//   C0_in/D0_in  initial key halves, sampled only when Start is accepted
//   Start        request a 16-round schedule (ignored unless idle)
//   Decrypt      schedule order, latched with Start
//   Round_ready  consumer accepts the current round
//   Busy         high from Start acceptance through the Done cycle
//   Round_valid  current round outputs are valid
//   Round_num    current round index 0..15
//   Ci_out/Di_out current rotated halves
//   Subkey       {Ci_out[55:8], Di_out[55:8]}
//   Done         one-cycle pulse after the last round is accepted
module key_round_scheduler #(
   parameter int unsigned HALF_W = 56,
   parameter int unsigned KEY_W  = 96
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [HALF_W-1:0] C0_in,
   input  logic [HALF_W-1:0] D0_in,
   input  logic              Start,
   input  logic              Decrypt,
   input  logic              Round_ready,
   output logic              Busy,
   output logic              Round_valid,
   output logic [3:0]        Round_num,
   output logic [HALF_W-1:0] Ci_out,
   output logic [HALF_W-1:0] Di_out,
   output logic [KEY_W-1:0]  Subkey,
   output logic              Done
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e            state_q, state_d;
   logic [HALF_W-1:0] c_q, c_d;
   logic [HALF_W-1:0] d_q, d_d;
   logic [3:0]        round_q, round_d;
   logic              dec_q, dec_d;

   // Shift amount for 1-based schedule index. Decrypt skips the first shift so
   // that its cumulative right rotation mirrors the encrypt sequence backwards.
   function automatic logic [2:0] shift_amt(input logic [4:0] idx, input logic dec);
      logic [2:0] amt;
      if (idx == 5'd1) begin
         amt = dec ? 3'd0 : 3'd2;
      end else if (idx == 5'd2 || idx == 5'd9 || idx == 5'd16) begin
         amt = 3'd2;
      end else begin
         amt = 3'd4;
      end
      return amt;
   endfunction

   // Rotate one half by 0, 2 or 4 positions.
   function automatic logic [HALF_W-1:0] rot(input logic [HALF_W-1:0] x,
                                             input logic [2:0]        amt,
                                             input logic              right);
      logic [HALF_W-1:0] y;
      y = x;
      if (amt == 3'd2) begin
         y = right ? {x[1:0], x[HALF_W-1:2]} : {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]};
      end else if (amt == 3'd4) begin
         y = right ? {x[3:0], x[HALF_W-1:4]} : {x[HALF_W-5:0], x[HALF_W-1:HALF_W-4]};
      end
      return y;
   endfunction

   logic [4:0] next_idx;
   logic [2:0] run_amt;
   logic [2:0] start_amt;

   assign next_idx  = {1'b0, round_q} + 5'd2;
   assign run_amt   = shift_amt(next_idx, dec_q);
   assign start_amt = shift_amt(5'd1, Decrypt);

   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      d_d     = d_q;
      round_d = round_q;
      dec_d   = dec_q;
      unique case (state_q)
         StIdle: begin
            if (Start) begin
               dec_d   = Decrypt;
               c_d     = rot(C0_in, start_amt, Decrypt);
               d_d     = rot(D0_in, start_amt, Decrypt);
               round_d = 4'd0;
               state_d = StRun;
            end
         end
         StRun: begin
            if (Round_ready) begin
               if (round_q == 4'd15) begin
                  // C/D and round hold their last values through Done and Idle
                  state_d = StDone;
               end else begin
                  round_d = round_q + 4'd1;
                  c_d     = rot(c_q, run_amt, dec_q);
                  d_d     = rot(d_q, run_amt, dec_q);
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= StIdle;
         c_q     <= '0;
         d_q     <= '0;
         round_q <= 4'd0;
         dec_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
         d_q     <= d_d;
         round_q <= round_d;
         dec_q   <= dec_d;
      end
   end

   assign Busy        = (state_q != StIdle);
   assign Round_valid = (state_q == StRun);
   assign Done        = (state_q == StDone);
   assign Round_num   = round_q;
   assign Ci_out      = c_q;
   assign Di_out      = d_q;
   assign Subkey      = {c_q[HALF_W-1:8], d_q[HALF_W-1:8]};

endmodule

// File: tb/tb_key_round_scheduler.sv
module tb_key_round_scheduler;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [55:0] C0_in;
   logic [55:0] D0_in;
   logic        Start;
   logic        Decrypt;
   logic        Round_ready;
   logic        Busy;
   logic        Round_valid;
   logic [3:0]  Round_num;
   logic [55:0] Ci_out;
   logic [55:0] Di_out;
   logic [95:0] Subkey;
   logic        Done;

   key_round_scheduler dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .C0_in       (C0_in),
      .D0_in       (D0_in),
      .Start       (Start),
      .Decrypt     (Decrypt),
      .Round_ready (Round_ready),
      .Busy        (Busy),
      .Round_valid (Round_valid),
      .Round_num   (Round_num),
      .Ci_out      (Ci_out),
      .Di_out      (Di_out),
      .Subkey      (Subkey),
      .Done        (Done)
   );

   always #5 Clk = ~Clk;

   int n_tests = 0;
   int n_fail  = 0;

   int enc_sched[16] = '{2, 2, 4, 4, 4, 4, 4, 4, 2, 4, 4, 4, 4, 4, 4, 2};
   int dec_sched[16] = '{0, 2, 4, 4, 4, 4, 4, 4, 2, 4, 4, 4, 4, 4, 4, 2};

   logic [55:0] cap_ci[16];
   logic [55:0] cap_di[16];
   logic [95:0] cap_sk[16];
   int          cap_done_cyc;
   bit          busy_ok, order_ok, hold_ok;

   typedef struct {
      logic [55:0] c0;
      logic [55:0] d0;
      bit          dec;
      int          rnd;
      logic [55:0] exp_ci;
   } vec_t;
   vec_t vecs[6];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference: total rotation after round r is the running sum of the schedule,
   // applied bit by bit with modular indexing.
   function automatic logic [55:0] model_half(input logic [55:0] x0, input bit dec, input int r);
      int cum;
      logic [55:0] y;
      cum = 0;
      for (int k = 0; k <= r; k++) cum += dec ? dec_sched[k] : enc_sched[k];
      cum = cum % 56;
      for (int i = 0; i < 56; i++) y[i] = dec ? x0[(i + cum) % 56] : x0[(i - cum + 56) % 56];
      return y;
   endfunction

   function automatic logic [55:0] rnd56();
      return 56'({$urandom(), $urandom()});
   endfunction

   task automatic do_reset();
      Reset = 1'b1;
      repeat (2) @(posedge Clk);
      #3 Reset = 1'b0;
      @(posedge Clk);
      #1;
   endtask

   // Entered #1 after an edge with the DUT idle; leaves #1 after the accepting edge.
   task automatic do_start(input logic [55:0] c0, input logic [55:0] d0, input bit dec);
      C0_in   = c0;
      D0_in   = d0;
      Decrypt = dec;
      Start   = 1'b1;
      @(posedge Clk);
      #1;
      Start   = 1'b0;
      C0_in   = rnd56();
      D0_in   = rnd56();
      Decrypt = ($urandom() & 1) != 0;
   endtask

   task automatic run_collect(input int stall_round, input int stall_len, input bit junk);
      int cyc;
      int seen;
      bit stalled;
      logic [207:0] snap;
      cyc = 1; seen = 0; stalled = 0;
      cap_done_cyc = 0; busy_ok = 1; order_ok = 1; hold_ok = 1;
      Round_ready = 1'b1;
      while (cyc <= 60 && cap_done_cyc == 0) begin
         Start = 1'b0;
         if (!Busy) busy_ok = 0;
         if (Done) begin
            cap_done_cyc = cyc;
            if (Round_valid) order_ok = 0;
            if (junk) Start = 1'b1;
         end else begin
            if (!Round_valid || Round_num != seen[3:0]) order_ok = 0;
            if (stall_len > 0 && !stalled && int'(Round_num) == stall_round) begin
               stalled = 1;
               Round_ready = 1'b0;
               snap = {Ci_out, Di_out, Subkey};
               repeat (stall_len) begin
                  @(posedge Clk);
                  #1;
                  cyc++;
                  if ({Ci_out, Di_out, Subkey} !== snap || int'(Round_num) != stall_round ||
                      !Round_valid || !Busy)
                     hold_ok = 0;
               end
               Round_ready = 1'b1;
            end
            cap_ci[Round_num] = Ci_out;
            cap_di[Round_num] = Di_out;
            cap_sk[Round_num] = Subkey;
            seen++;
            if (junk && (Round_num == 4'd3 || Round_num == 4'd15)) begin
               Start   = 1'b1;
               C0_in   = rnd56();
               D0_in   = rnd56();
               Decrypt = ~Decrypt;
            end
         end
         @(posedge Clk);
         #1;
         cyc++;
      end
      Start = 1'b0;
   endtask

   task automatic check_run(input logic [55:0] c0, input logic [55:0] d0, input bit dec,
                            input int exp_done, input string tag);
      logic [55:0] eci, edi;
      for (int r = 0; r < 16; r++) begin
         eci = model_half(c0, dec, r);
         edi = model_half(d0, dec, r);
         check($sformatf("%s r%0d Ci", tag, r), 128'(cap_ci[r]), 128'(eci));
         check($sformatf("%s r%0d Di", tag, r), 128'(cap_di[r]), 128'(edi));
         check($sformatf("%s r%0d Subkey", tag, r), 128'(cap_sk[r]),
               128'({eci[55:8], edi[55:8]}));
      end
      check({tag, " done cycle"}, 128'(cap_done_cyc), 128'(exp_done));
      check({tag, " busy held"}, 128'(busy_ok), 128'(1));
      check({tag, " round order"}, 128'(order_ok), 128'(1));
      check({tag, " stall hold"}, 128'(hold_ok), 128'(1));
      eci = model_half(c0, dec, 15);
      edi = model_half(d0, dec, 15);
      check({tag, " idle after done"}, 128'({Busy, Round_valid, Done, Round_num, Ci_out, Di_out}),
            128'({3'b000, 4'd15, eci, edi}));
   endtask

   initial begin
      logic [55:0] c0, d0;
      bit dec;
      bit bad;

      vecs[0] = '{56'h1, 56'h0, 1'b0, 0,  56'h4};
      vecs[1] = '{56'h1, 56'h0, 1'b0, 1,  56'h10};
      vecs[2] = '{56'h1, 56'h0, 1'b0, 15, 56'h1};
      vecs[3] = '{56'h1, 56'h0, 1'b1, 0,  56'h1};
      vecs[4] = '{56'h1, 56'h0, 1'b1, 1,  56'h40000000000000};
      vecs[5] = '{56'h1, 56'h0, 1'b1, 15, 56'h4};

      Reset = 1'b1; Start = 1'b0; Decrypt = 1'b0; Round_ready = 1'b0;
      C0_in = '0; D0_in = '0;
      #1;
      check("reset ctrl", 128'({Busy, Round_valid, Done, Round_num}), 128'(0));
      check("reset halves", 128'({Ci_out, Di_out}), 128'(0));
      check("reset subkey", 128'(Subkey), 128'(0));
      do_reset();

      // Table of directed round values
      for (int v = 0; v < 6; v++) begin
         do_start(vecs[v].c0, vecs[v].d0, vecs[v].dec);
         run_collect(0, 0, 0);
         check($sformatf("vec%0d Ci r%0d", v, vecs[v].rnd), 128'(cap_ci[vecs[v].rnd]),
               128'(vecs[v].exp_ci));
         check($sformatf("vec%0d done cycle", v), 128'(cap_done_cyc), 128'(17));
      end

      // Subkey bit selection
      do_start(56'hFFFFFFFFFFFF00, 56'h0, 1'b1);
      run_collect(0, 0, 0);
      check("subkey r0", 128'(cap_sk[0]), 128'({48'hFFFFFFFFFFFF, 48'h0}));

      // Random keys against the model
      for (int i = 0; i < 8; i++) begin
         c0 = rnd56(); d0 = rnd56(); dec = (i % 2) == 1;
         do_start(c0, d0, dec);
         run_collect(0, 0, 0);
         check_run(c0, d0, dec, 17, $sformatf("rand%0d", i));
      end

      // Backpressure: 3 stalled cycles at round 5
      c0 = rnd56(); d0 = rnd56();
      do_start(c0, d0, 1'b0);
      run_collect(5, 3, 0);
      check_run(c0, d0, 1'b0, 20, "stall");

      // Start, Decrypt and key changes while busy and in Done are ignored
      c0 = rnd56(); d0 = rnd56();
      do_start(c0, d0, 1'b1);
      run_collect(0, 0, 1);
      check_run(c0, d0, 1'b1, 17, "busystart");
      c0 = rnd56(); d0 = rnd56();
      do_start(c0, d0, 1'b0);
      run_collect(0, 0, 0);
      check_run(c0, d0, 1'b0, 17, "after idle");

      // Asynchronous reset mid-schedule
      c0 = rnd56(); d0 = rnd56();
      do_start(c0, d0, 1'b0);
      Round_ready = 1'b1;
      repeat (8) @(posedge Clk);
      #1;
      check("pre-reset round", 128'(Round_num), 128'(8));
      check("pre-reset Ci", 128'(Ci_out), 128'(model_half(c0, 1'b0, 8)));
      #3 Reset = 1'b1;
      #1;
      check("async reset ctrl", 128'({Busy, Round_valid, Done, Round_num}), 128'(0));
      check("async reset halves", 128'({Ci_out, Di_out}), 128'(0));
      check("async reset subkey", 128'(Subkey), 128'(0));
      // Start together with reset must lose
      Start = 1'b1;
      @(posedge Clk);
      #1;
      check("start under reset", 128'({Busy, Round_valid}), 128'(0));
      Start = 1'b0;
      #2 Reset = 1'b0;
      bad = 0;
      repeat (20) begin
         @(posedge Clk);
         #1;
         if (Done || Busy) bad = 1;
      end
      check("no done after reset", 128'(bad), 128'(0));
      c0 = rnd56(); d0 = rnd56();
      do_start(c0, d0, 1'b1);
      run_collect(0, 0, 0);
      check_run(c0, d0, 1'b1, 17, "post reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
